// File: rtl/latch_bank_write_arbiter.sv
// Round-robin owner of a single level-sensitive latch-bank write port.
// Each grant runs a fixed setup / enable-pulse / hold sequence, so latch_d never moves while the bank is transparent.
module latch_bank_write_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int OPEN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [WIDTH-1:0]           latch_d,
  output logic                       latch_en,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic [1:0]                 state_dbg
);

  // Handshake: a requester holds req[i] high until it sees done[i].
  // gnt[i] stays high from the grant until the HOLD cycle ends.
  // done[i] pulses for exactly one cycle, in HOLD.
  // wdata slice i is captured once, on the grant edge.
  // A req that is still high in the IDLE cycle after done counts as a new request.

  localparam int OW = $clog2(N_REQ);
  localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(OPEN_CYCLES - 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  generate
    if (OPEN_CYCLES < 1) begin : g_bad_open_cycles
      $fatal(1, "OPEN_CYCLES must be at least 1");
    end
  endgenerate

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] winner;
  logic [OW-1:0] idx;
  logic          any_req;

  assign state_dbg = state;

  // The first set request at or above rr_ptr wins, wrapping around to index 0.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = OW'((int'(rr_ptr) + i) % N_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      gnt      <= '0;
      done     <= '0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      busy     <= 1'b0;
      owner    <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state   <= ST_SETUP;
            gnt     <= N_REQ'(1) << winner;
            owner   <= winner;
            latch_d <= wdata[winner*WIDTH +: WIDTH];
            busy    <= 1'b1;
          end
        end
        ST_SETUP: begin
          state    <= ST_OPEN;
          latch_en <= 1'b1;
          cnt      <= CNT_LOAD;
        end
        ST_OPEN: begin
          if (cnt == '0) begin
            state    <= ST_HOLD;
            latch_en <= 1'b0;
            done     <= gnt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          state  <= ST_IDLE;
          gnt    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Bench for latch_bank_write_arbiter: a cycle table for reset and a first write, then hand-written multi-cycle sequences.
// A behavioural D-latch sits on latch_d/latch_en, and completed writes are scored against an expected queue.
module tb_latch_bank_write_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int OPEN_CYCLES = 2;
  localparam int EW = 2 + WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [31:0]      wdata;
  logic [3:0]       gnt;
  logic [3:0]       done;
  logic [7:0]       latch_d;
  logic             latch_en;
  logic             busy;
  logic [1:0]       owner;
  logic [1:0]       state_dbg;
  logic [7:0]       q;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  latch_bank_write_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .OPEN_CYCLES(OPEN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .done(done), .latch_d(latch_d), .latch_en(latch_en),
    .busy(busy), .owner(owner), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural D-latch bank
  always @(latch_en or latch_d) if (latch_en) q = latch_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic push_exp(input logic [1:0] who, input logic [7:0] data);
    exp_q.push_back({who, data});
  endtask

  // scoreboard: each done pulse pops one expected {owner, data} record
  logic [3:0] prev_done = '0;
  always @(posedge clk) begin
    logic [EW-1:0] rec;
    #2;
    if (!rst) begin
      check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      check("done_onehot0", {31'd0, $onehot0(done)}, 32'd1);
      if (done != '0) begin
        check("done_width", {28'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=%0h required=none", done);
        end else begin
          rec = exp_q.pop_front();
          check("sb_done", {28'd0, done}, {28'd0, onehot(rec[EW-1:WIDTH])});
          check("sb_owner", {30'd0, owner}, {30'd0, rec[EW-1:WIDTH]});
          check("sb_latch_d", {24'd0, latch_d}, {24'd0, rec[WIDTH-1:0]});
          check("sb_q", {24'd0, q}, {24'd0, rec[WIDTH-1:0]});
        end
      end
    end
    prev_done = done;
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       push;
    logic [EW-1:0] rec;
    logic [3:0] gnt;
    logic       en;
    logic [3:0] done;
    logic       busy;
    logic [7:0] d;
    logic [1:0] owner;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, then requester 2 writes 8'h3C
    //            rst  req      push  rec           gnt      en    done     busy  d      own   st
    vecs[0] = '{1'b1, 4'b0000, 1'b0, '0,            4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0};
    vecs[1] = '{1'b0, 4'b0100, 1'b1, {2'd2, 8'h3C}, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd2, 2'd1};
    vecs[2] = '{1'b0, 4'b0100, 1'b0, '0,            4'b0100, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd2, 2'd2};
    vecs[3] = '{1'b0, 4'b0100, 1'b0, '0,            4'b0100, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd2, 2'd2};
    vecs[4] = '{1'b0, 4'b0100, 1'b0, '0,            4'b0100, 1'b0, 4'b0100, 1'b1, 8'h3C, 2'd2, 2'd3};
    vecs[5] = '{1'b0, 4'b0000, 1'b0, '0,            4'b0000, 1'b0, 4'b0000, 1'b0, 8'h3C, 2'd2, 2'd0};
    vecs[6] = '{1'b0, 4'b0000, 1'b0, '0,            4'b0000, 1'b0, 4'b0000, 1'b0, 8'h3C, 2'd2, 2'd0};

    rst = 1'b1;
    req = '0;
    wdata = 32'h443C2211;
    #1;
    check("rst_latch_en", {31'd0, latch_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      if (vecs[i].push) exp_q.push_back(vecs[i].rec);
      tick();
      check($sformatf("v%0d_gnt", i), {28'd0, gnt}, {28'd0, vecs[i].gnt});
      check($sformatf("v%0d_en", i), {31'd0, latch_en}, {31'd0, vecs[i].en});
      check($sformatf("v%0d_done", i), {28'd0, done}, {28'd0, vecs[i].done});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("v%0d_d", i), {24'd0, latch_d}, {24'd0, vecs[i].d});
      check($sformatf("v%0d_owner", i), {30'd0, owner}, {30'd0, vecs[i].owner});
      check($sformatf("v%0d_state", i), {30'd0, state_dbg}, {30'd0, vecs[i].st});
    end
    check("t1_q", {24'd0, q}, 32'h3C);

    // abort: reset asserted while latch_en is high
    wdata = 32'h443C7711;
    req = 4'b0010;
    tick();
    check("t2_gnt", {28'd0, gnt}, 32'b0010);
    tick();
    check("t2_en_open", {31'd0, latch_en}, 32'd1);
    check("t2_q_open", {24'd0, q}, 32'h77);
    rst = 1'b1;
    #1;
    check("t2_en_async", {31'd0, latch_en}, 32'd0);
    check("t2_gnt_async", {28'd0, gnt}, 32'd0);
    check("t2_busy_async", {31'd0, busy}, 32'd0);
    check("t2_state_async", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    req = '0;
    repeat (3) begin
      tick();
      check("t2_no_done", {28'd0, done}, 32'd0);
    end
    check("t2_q_held", {24'd0, q}, 32'h77);

    // contention: all four requesting, strict round-robin, 5 cycles apart
    wdata = 32'h44332211;
    req = 4'b1111;
    for (int g = 0; g < 4; g++) push_exp(2'(g), 8'(8'h11 * (g + 1)));
    for (int g = 0; g < 4; g++) begin
      tick();
      check("t3_gnt", {28'd0, gnt}, {28'd0, onehot(2'(g))});
      check("t3_latch_d", {24'd0, latch_d}, 32'(8'h11 * (g + 1)));
      repeat (4) tick();
      check("t3_idle_gap", {31'd0, busy}, 32'd0);
    end
    req = '0;
    tick();
    check("t3_end_gnt", {28'd0, gnt}, 32'd0);

    // fairness: req[0] held, req[3] raised during requester 0's OPEN
    push_exp(2'd0, 8'h11);
    req = 4'b0001;
    tick();
    check("t4_gnt0", {28'd0, gnt}, 32'b0001);
    tick();
    req = 4'b1001;
    push_exp(2'd3, 8'h44);
    push_exp(2'd0, 8'h11);
    repeat (3) tick();
    tick();
    check("t4_gnt3", {28'd0, gnt}, 32'b1000);
    repeat (3) tick();
    req = 4'b0001;
    repeat (2) tick();
    check("t4_gnt0_again", {28'd0, gnt}, 32'b0001);
    repeat (3) tick();
    req = '0;
    tick();

    // data stability: wdata changes after grant are ignored
    wdata = 32'h443CA511;
    push_exp(2'd1, 8'hA5);
    req = 4'b0010;
    tick();
    check("t5_latch_d_grant", {24'd0, latch_d}, 32'hA5);
    wdata = 32'h443C5A11;
    tick();
    check("t5_latch_d_open", {24'd0, latch_d}, 32'hA5);
    check("t5_q_open", {24'd0, q}, 32'hA5);
    repeat (2) tick();
    req = '0;
    tick();
    check("t5_q_idle", {24'd0, q}, 32'hA5);
    push_exp(2'd1, 8'h5A);
    req = 4'b0010;
    tick();
    check("t5_d_new_setup", {24'd0, latch_d}, 32'h5A);
    check("t5_en_setup", {31'd0, latch_en}, 32'd0);
    check("t5_q_closed", {24'd0, q}, 32'hA5);
    repeat (3) tick();
    req = '0;
    tick();

    // early drop: req[1] released during SETUP, write still completes
    wdata = 32'hD4C3B2A1;
    push_exp(2'd1, 8'hB2);
    req = 4'b0010;
    tick();
    check("t6_gnt1", {28'd0, gnt}, 32'b0010);
    req = 4'b0101;
    push_exp(2'd2, 8'hC3);
    push_exp(2'd0, 8'hA1);
    repeat (4) tick();
    tick();
    check("t6_gnt2", {28'd0, gnt}, 32'b0100);
    repeat (3) tick();
    req = 4'b0001;
    repeat (2) tick();
    check("t6_gnt0", {28'd0, gnt}, 32'b0001);
    repeat (3) tick();
    req = '0;
    repeat (2) tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
